short_plateau_detect: RTL

- Sits directly downstream of the short-preamble packet-decision stage. Consumes its per-sample decision bit and that bit's strobe.
- Declares a short-preamble plateau once the decision holds high for a minimum run of strobes. A small number of isolated low decisions is tolerated inside that run.
- While locked, it counts strobes to give the long-sync/CFO stages a sample index. It releases on a sustained drop or on timeout, then ignores input for a hold-off window.

---
 rtl/short_plateau_detect_pkg.sv | 29 ++
 rtl/short_plateau_detect_if.sv | 47 ++++
 rtl/short_plateau_detect_sat_strobe_counter.sv | 43 ++++
 rtl/short_plateau_detect.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/short_plateau_detect_pkg.sv
// short_plateau_detect_pkg
// Shared definitions for the short-preamble sync chain: the plateau FSM state
// encoding, the default counter width and the default plateau constants that
// the long-sync window logic also uses.
// No ports (package).

package short_plateau_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLDOFF = 2'd3
  } plateau_state_e;

  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_MIN_PLATEAU  = 100;
  localparam int unsigned DEF_MAX_GAP      = 2;
  localparam int unsigned DEF_DROP_CNT     = 32;
  localparam int unsigned DEF_LOCK_TIMEOUT = 400;
  localparam int unsigned DEF_HOLDOFF      = 64;

  // True when value is representable in an unsigned counter of the given width.
  function automatic bit fits_cnt(input longint unsigned value, input int unsigned width);
    if (width >= 64) return 1'b1;
    return value < (64'd1 << width);
  endfunction

endpackage

// File: rtl/short_plateau_detect_if.sv
// short_plateau_detect_if
// Bundles the decision-bit input stream and the plateau/sample-index outputs.
//   pak_det, pak_strobe          : decision bit and its one-cycle qualifier
//   short_det, short_det_strobe  : locked level and lock-entry pulse
//   release_strobe, timeout_flag : lock-exit pulse and its cause
//   sample_idx, idx_strobe       : per-strobe index while locked and its qualifier
//   plateau_len, plateau_len_strobe : only with PLATEAU_LEN_EN defined
// Modports: master = upstream decision stage / consumer side, slave = detector.

interface short_plateau_detect_if
  import short_plateau_detect_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             pak_det;
  logic             pak_strobe;
  logic             short_det;
  logic             short_det_strobe;
  logic             release_strobe;
  logic             timeout_flag;
  logic [CNT_W-1:0] sample_idx;
  logic             idx_strobe;
`ifdef PLATEAU_LEN_EN
  logic [CNT_W-1:0] plateau_len;
  logic             plateau_len_strobe;
`endif

  modport master (
    output pak_det, pak_strobe,
`ifdef PLATEAU_LEN_EN
    input  plateau_len, plateau_len_strobe,
`endif
    input  short_det, short_det_strobe, release_strobe, timeout_flag,
           sample_idx, idx_strobe
  );

  modport slave (
    input  pak_det, pak_strobe,
`ifdef PLATEAU_LEN_EN
    output plateau_len, plateau_len_strobe,
`endif
    output short_det, short_det_strobe, release_strobe, timeout_flag,
           sample_idx, idx_strobe
  );

endinterface

// File: rtl/short_plateau_detect_sat_strobe_counter.sv
// sat_strobe_counter
// Strobe-qualified unsigned counter with clear, saturating increment and a
// terminal compare against the value the counter would take after this
// increment, so the caller can act on the same strobe that reaches it.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : strobe qualifier; nothing changes when low
//   clr, inc   : clear (wins) / increment request
//   terminal   : compare value
//   count      : current registered count
//   hit        : (count + 1) >= terminal, evaluated unsigned without wrap

module sat_strobe_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W:0] count_plus;

  // One extra bit so the all-ones count compares as 2**CNT_W instead of wrapping.
  assign count_plus = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign hit        = count_plus >= {1'b0, terminal};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (clr) begin
        count <= '0;
      end else if (inc && !(&count)) begin
        count <= count_plus[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/short_plateau_detect.sv
// short_plateau_detect
// Declares a short-preamble plateau once the packet decision stays high for
// MIN_PLATEAU strobes (short low gaps tolerated), indexes strobes while
// locked, releases on a sustained drop or a lock timeout, then ignores input
// for a hold-off window. Everything advances only on pak_strobe; all outputs
// appear one cycle after the qualifying strobe.
//   CLK      : system clock
//   s_RST_n  : synchronous active-low reset
//   bus      : short_plateau_detect_if.slave (decision in, plateau outputs)
// Optional feature macro: PLATEAU_LEN_EN adds plateau_len/plateau_len_strobe.

module short_plateau_detect
  import short_plateau_detect_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned MIN_PLATEAU  = DEF_MIN_PLATEAU,
  parameter int unsigned MAX_GAP      = DEF_MAX_GAP,
  parameter int unsigned DROP_CNT     = DEF_DROP_CNT,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned HOLDOFF      = DEF_HOLDOFF
) (
  input  logic                  CLK,
  input  logic                  s_RST_n,
  short_plateau_detect_if.slave bus
);

  // Every threshold must be representable in the counters. The gap limit is
  // compared as gap+1 > MAX_GAP, so MAX_GAP+1 has to fit as well.
  if (!fits_cnt(longint'(MIN_PLATEAU), CNT_W) ||
      !fits_cnt(longint'(MAX_GAP) + 1, CNT_W) ||
      !fits_cnt(longint'(DROP_CNT), CNT_W) ||
      !fits_cnt(longint'(LOCK_TIMEOUT), CNT_W) ||
      !fits_cnt(longint'(HOLDOFF), CNT_W)) begin : g_param_check
    $error("short_plateau_detect: a threshold parameter does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] RUN_TERM  = CNT_W'(MIN_PLATEAU);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(MAX_GAP + 1);
  localparam logic [CNT_W-1:0] MISS_TERM = CNT_W'(DROP_CNT);
  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLDOFF);

  plateau_state_e state_q, state_d;

  logic run_clr, run_inc, run_hit;
  logic gap_clr, gap_inc, gap_hit;
  logic miss_clr, miss_inc, miss_hit;
  logic lock_clr, lock_inc, lock_hit;
  logic hold_clr, hold_inc, hold_hit;
  logic [CNT_W-1:0] run_cnt, gap_cnt, miss_cnt, lock_cnt, hold_cnt;

  logic enter_lock;
  logic short_det_strobe_d, release_d, timeout_d, idx_strobe_d;
  logic short_det_strobe_q, release_q, timeout_q, idx_strobe_q;

  sat_strobe_counter #(.CNT_W(CNT_W)) u_run (
    .clk(CLK), .rst_n(s_RST_n), .en(bus.pak_strobe), .clr(run_clr), .inc(run_inc),
    .terminal(RUN_TERM), .count(run_cnt), .hit(run_hit)
  );

  sat_strobe_counter #(.CNT_W(CNT_W)) u_gap (
    .clk(CLK), .rst_n(s_RST_n), .en(bus.pak_strobe), .clr(gap_clr), .inc(gap_inc),
    .terminal(GAP_TERM), .count(gap_cnt), .hit(gap_hit)
  );

  sat_strobe_counter #(.CNT_W(CNT_W)) u_miss (
    .clk(CLK), .rst_n(s_RST_n), .en(bus.pak_strobe), .clr(miss_clr), .inc(miss_inc),
    .terminal(MISS_TERM), .count(miss_cnt), .hit(miss_hit)
  );

  // The lock counter doubles as sample_idx: cleared on lock entry, +1 per
  // LOCKED strobe, so it already equals the strobes seen since lock.
  sat_strobe_counter #(.CNT_W(CNT_W)) u_lock (
    .clk(CLK), .rst_n(s_RST_n), .en(bus.pak_strobe), .clr(lock_clr), .inc(lock_inc),
    .terminal(LOCK_TERM), .count(lock_cnt), .hit(lock_hit)
  );

  sat_strobe_counter #(.CNT_W(CNT_W)) u_hold (
    .clk(CLK), .rst_n(s_RST_n), .en(bus.pak_strobe), .clr(hold_clr), .inc(hold_inc),
    .terminal(HOLD_TERM), .count(hold_cnt), .hit(hold_hit)
  );

  // Only the terminal compares of these counters drive decisions.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{run_cnt, gap_cnt, miss_cnt, hold_cnt};

  // State register.
  always_ff @(posedge CLK) begin
    if (!s_RST_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter control. Nothing moves without pak_strobe. A lock
  // or release decided in a branch is finished off by the shared blocks at
  // the end so both entry paths into LOCKED clear the same counters.
  always_comb begin
    state_d            = state_q;
    run_clr            = 1'b0;
    run_inc            = 1'b0;
    gap_clr            = 1'b0;
    gap_inc            = 1'b0;
    miss_clr           = 1'b0;
    miss_inc           = 1'b0;
    lock_clr           = 1'b0;
    lock_inc           = 1'b0;
    hold_clr           = 1'b0;
    hold_inc           = 1'b0;
    enter_lock         = 1'b0;
    short_det_strobe_d = 1'b0;
    release_d          = 1'b0;
    timeout_d          = 1'b0;
    idx_strobe_d       = 1'b0;

    if (bus.pak_strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pak_det) begin
            state_d = ST_ARM;
            gap_clr = 1'b1;
            if (run_hit) enter_lock = 1'b1;
            else         run_inc    = 1'b1;
          end
        end
        ST_ARM: begin
          if (bus.pak_det) begin
            gap_clr = 1'b1;
            if (run_hit) enter_lock = 1'b1;
            else         run_inc    = 1'b1;
          end else if (gap_hit) begin
            state_d = ST_IDLE;
            run_clr = 1'b1;
            gap_clr = 1'b1;
          end else begin
            gap_inc = 1'b1;
          end
        end
        ST_LOCKED: begin
          idx_strobe_d = 1'b1;
          lock_inc     = 1'b1;
          if (bus.pak_det) miss_clr = 1'b1;
          else             miss_inc = 1'b1;
          // Drop is checked first so it wins a tie with the timeout.
          if (!bus.pak_det && miss_hit) begin
            release_d = 1'b1;
          end else if (lock_hit) begin
            release_d = 1'b1;
            timeout_d = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (hold_hit) begin
            state_d  = ST_IDLE;
            hold_clr = 1'b1;
            lock_clr = 1'b1;
          end else begin
            hold_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (enter_lock) begin
        state_d            = ST_LOCKED;
        short_det_strobe_d = 1'b1;
        run_clr            = 1'b1;
        gap_clr            = 1'b1;
        miss_clr           = 1'b1;
        lock_clr           = 1'b1;
      end

      if (release_d) begin
        state_d  = ST_HOLDOFF;
        miss_clr = 1'b1;
        hold_clr = 1'b1;
      end
    end
  end

  // Pulse outputs are re-registered every cycle so they last exactly one cycle.
  always_ff @(posedge CLK) begin
    if (!s_RST_n) begin
      short_det_strobe_q <= 1'b0;
      release_q          <= 1'b0;
      timeout_q          <= 1'b0;
      idx_strobe_q       <= 1'b0;
    end else begin
      short_det_strobe_q <= short_det_strobe_d;
      release_q          <= release_d;
      timeout_q          <= timeout_d;
      idx_strobe_q       <= idx_strobe_d;
    end
  end

  assign bus.short_det        = (state_q == ST_LOCKED);
  assign bus.short_det_strobe = short_det_strobe_q;
  assign bus.release_strobe   = release_q;
  assign bus.timeout_flag     = timeout_q;
  assign bus.sample_idx       = lock_cnt;
  assign bus.idx_strobe       = idx_strobe_q;

`ifdef PLATEAU_LEN_EN
  logic [CNT_W-1:0] lock_len_next;
  logic [CNT_W-1:0] plateau_len_q;
  logic             plateau_len_strobe_q;

  // Length includes the releasing strobe, matching the last sample_idx.
  assign lock_len_next = (&lock_cnt) ? lock_cnt : lock_cnt + 1'b1;

  // Plateau length is captured only at release and held until the next one.
  always_ff @(posedge CLK) begin
    if (!s_RST_n) begin
      plateau_len_q        <= '0;
      plateau_len_strobe_q <= 1'b0;
    end else begin
      plateau_len_strobe_q <= release_d;
      if (release_d) plateau_len_q <= lock_len_next;
    end
  end

  assign bus.plateau_len        = plateau_len_q;
  assign bus.plateau_len_strobe = plateau_len_strobe_q;
`endif

endmodule
